hebb_trainer: RTL
=================

// Module: hebb_trainer
// PURPOSE
//  Builds the Hopfield weight matrix from stored patterns (Hebbian rule). It is the writer of the
//  flat W bus that the recall network reads. Patterns arrive one per valid/ready handshake and
//  are folded in one row per cycle. W is held stable and flagged valid between updates.
// PARAMETERS
//  N      9   neurons per pattern; W is N x N
//  SIZE   32  bits per weight, signed two's complement
//  P_MAX  4   max patterns stored before clear; further patterns stalled
// PORTS
//  clk        in   1           single clock, all logic on posedge
//  rst        in   1           synchronous reset, active-high
//  clear      in   1           1-cycle pulse: zero W and count (honoured in IDLE only)
//  pat_valid  in   1           pattern offered
//  pat_ready  out  1           = (state==IDLE) && (count<P_MAX) && !clear
//  pat        in   N           bipolar pattern: bit j=1 -> +1, 0 -> -1; pat[N-1] is element 0
//  W          out  SIZE*N*N    row i at [N*SIZE*(i+1)-1 : N*SIZE*i]; in row, elem j at [SIZE*(N-j)-1 : SIZE*(N-j-1)]
//  w_valid    out  1           W stable and count>=1
//  count      out  $clog2(P_MAX+1)  patterns stored
//  busy       out  1           state != IDLE
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): W=0, count=0, state=IDLE, w_valid=0, busy=0. rst beats all.
//  - States: IDLE, UPDATE, CLEAR.
//  - IDLE: clear=1 -> CLEAR (pattern never accepted that cycle; pat_ready low).
//    else pat_valid&&pat_ready -> latch pat into pat_q, row=0 -> UPDATE.
//  - UPDATE: per cycle, row r updated: w[r][j] += (pat_q_r==pat_q_j) ? +1 : -1 for j!=r;
//    w[r][r] stays 0. Add saturates to [-2^(SIZE-1), 2^(SIZE-1)-1]. r==N-1 -> IDLE, count++.
//  - Timing: handshake at cycle t; UPDATE cycles t+1..t+N (row i written at end of t+1+i);
//    IDLE, busy=0, w_valid=1 from t+N+1. Throughput: one pattern per N+1 cycles.
//  - CLEAR: one cycle; all W=0, count=0 at its end; -> IDLE; w_valid=0 until next pattern done.
//  - clear asserted outside IDLE is ignored (not queued). pat_valid outside IDLE is stalled.
//  - count==P_MAX: pat_ready=0 until clear or rst; w_valid stays 1.
//  - w_valid=0 and busy=1 throughout UPDATE; W rows mid-update are partial, not for use.
//  - rst mid-UPDATE: all of W discarded to 0, count=0; partial pattern lost.
//  - pat_q held stable through UPDATE; pat input may change after handshake.
//  - Result symmetric: w[i][j]==w[j][i] after every completed pattern.
// STRUCTURE
//  - hopfield_pkg: defaults N/SIZE, state encoding, W/S slice index functions (shared with net).
//  - Sub-module hebb_row_update: combinational, pat_q, row index, old row (N*SIZE) ->
//    new row with saturating +/-1 and zeroed diagonal. Top holds FSM, counters, W regs.
// TESTING
//  1 rst, pat=9'h1FF -> after 10 cycles all off-diag w=+1, diag 0, w_valid=1, count=1.
//  2 then pat=9'h000 -> off-diag w=+2 (p and ~p same product), count=2; symmetry checked.
//  3 pat=9'b101010101 from clear -> w[0][1]=-1, w[0][2]=+1, w[8][8]=0; transposes equal.
//  4 SIZE=2 override, 3x pat=9'h1FF -> off-diag w held at +1 (sat), no wrap to -2.
//  5 P_MAX patterns stored -> pat_ready=0, pat_valid held high not accepted; clear ->
//    next cycle W=0, count=0, pat_ready=1; clear+pat_valid same cycle -> pattern not taken.
//  6 rst at UPDATE row 4 -> next cycle W=0, count=0, IDLE; clear during UPDATE ignored.

Source files
------------

// File: rtl/hopfield_pkg.sv
// Shared Hopfield definitions: default dimensions, trainer state encoding and
// flat-bus slice index helpers used by both the trainer and the recall network.
package hopfield_pkg;

    localparam int unsigned N_DEF     = 9;
    localparam int unsigned SIZE_DEF  = 32;
    localparam int unsigned P_MAX_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_CLEAR  = 2'd2
    } hebb_state_e;

    // LSB of row i inside the flat W bus
    function automatic int unsigned row_lsb(input int unsigned n, input int unsigned size,
                                            input int unsigned i);
        return n * size * i;
    endfunction

    // LSB of element w[i][j]; element 0 of a row sits in the top slice
    function automatic int unsigned w_lsb(input int unsigned n, input int unsigned size,
                                          input int unsigned i, input int unsigned j);
        return n * size * i + size * (n - j - 1);
    endfunction

    // Bit position of pattern/state element j (element 0 is the MSB)
    function automatic int unsigned s_idx(input int unsigned n, input int unsigned j);
        return n - 1 - j;
    endfunction

endpackage

// File: rtl/hebb_row_update.sv
// Combinational Hebbian row update: adds the +/-1 outer-product term of one
// pattern to a single weight row, saturating, with the diagonal forced to zero.
module hebb_row_update
    import hopfield_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned SIZE  = SIZE_DEF,
    parameter int unsigned ROW_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]      pat_i,
    input  logic [ROW_W-1:0]  row_i,
    input  logic [N*SIZE-1:0] row_old_i,
    output logic [N*SIZE-1:0] row_new_o
);

    localparam logic [SIZE-1:0] W_MAX = {1'b0, {(SIZE-1){1'b1}}};
    localparam logic [SIZE-1:0] W_MIN = {1'b1, {(SIZE-1){1'b0}}};

    logic            row_bit;
    logic [SIZE-1:0] elem;
    logic [SIZE-1:0] elem_new;

    always_comb begin
        row_bit = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (row_i == ROW_W'(k)) row_bit = pat_i[s_idx(N, k)];
        end
    end

    // Equal signs reinforce the link, opposite signs weaken it; clamp at the rails
    always_comb begin
        row_new_o = '0;
        elem      = '0;
        elem_new  = '0;
        for (int j = 0; j < N; j++) begin
            elem = row_old_i[w_lsb(N, SIZE, 0, j) +: SIZE];
            if (row_i == ROW_W'(j)) begin
                elem_new = '0;
            end else if (pat_i[s_idx(N, j)] == row_bit) begin
                elem_new = (elem == W_MAX) ? elem : elem + SIZE'(1);
            end else begin
                elem_new = (elem == W_MIN) ? elem : elem - SIZE'(1);
            end
            row_new_o[w_lsb(N, SIZE, 0, j) +: SIZE] = elem_new;
        end
    end

endmodule

// File: rtl/hebb_trainer.sv
// Hopfield weight-matrix builder: folds bipolar patterns into W one row per
// cycle using the Hebbian rule and publishes W with a valid flag when stable.
module hebb_trainer
    import hopfield_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned SIZE  = SIZE_DEF,
    parameter int unsigned P_MAX = P_MAX_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         pat_valid,
    output logic                         pat_ready,
    input  logic [N-1:0]                 pat,
    output logic [SIZE*N*N-1:0]          W,
    output logic                         w_valid,
    output logic [$clog2(P_MAX+1)-1:0]   count,
    output logic                         busy
);

    localparam int unsigned ROW_BITS = N * SIZE;
    localparam int unsigned ROW_W    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W    = $clog2(P_MAX + 1);

    hebb_state_e         state_q, state_d;
    logic [SIZE*N*N-1:0] w_q, w_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [N-1:0]        pat_q, pat_d;
    logic [ROW_BITS-1:0] old_row;
    logic [ROW_BITS-1:0] new_row;
    logic                last_row;

    assign last_row = (row_q == ROW_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (clear)                       state_d = ST_CLEAR;
                else if (pat_valid && pat_ready) state_d = ST_UPDATE;
            end
            ST_UPDATE: if (last_row) state_d = ST_IDLE;
            ST_CLEAR:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pat_ready = (state_q == ST_IDLE) && (count_q < CNT_W'(P_MAX)) && !clear;
        busy      = (state_q != ST_IDLE);
        w_valid   = (state_q == ST_IDLE) && (count_q != '0);
    end

    always_comb begin
        old_row = '0;
        for (int i = 0; i < N; i++) begin
            if (row_q == ROW_W'(i)) old_row = w_q[row_lsb(N, SIZE, i) +: ROW_BITS];
        end
    end

    hebb_row_update #(
        .N     (N),
        .SIZE  (SIZE),
        .ROW_W (ROW_W)
    ) u_row_update (
        .pat_i     (pat_q),
        .row_i     (row_q),
        .row_old_i (old_row),
        .row_new_o (new_row)
    );

    // Datapath next-state: latch on handshake, write one row per UPDATE cycle
    always_comb begin
        w_d     = w_q;
        count_d = count_q;
        row_d   = row_q;
        pat_d   = pat_q;
        case (state_q)
            ST_IDLE: begin
                if (!clear && pat_valid && pat_ready) begin
                    pat_d = pat;
                    row_d = '0;
                end
            end
            ST_UPDATE: begin
                for (int i = 0; i < N; i++) begin
                    if (row_q == ROW_W'(i)) w_d[row_lsb(N, SIZE, i) +: ROW_BITS] = new_row;
                end
                if (last_row) begin
                    row_d   = '0;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end
            ST_CLEAR: begin
                w_d     = '0;
                count_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q     <= '0;
            count_q <= '0;
            row_q   <= '0;
            pat_q   <= '0;
        end else begin
            w_q     <= w_d;
            count_q <= count_d;
            row_q   <= row_d;
            pat_q   <= pat_d;
        end
    end

    assign W     = w_q;
    assign count = count_q;

endmodule
